// File: rtl/bus_copy_initiator_if.sv
// Femto peripheral bus definitions and the requester/responder interface
// shared by the copy initiator and its responders.
package bus_copy_pkg;
  localparam int BUS_WIDTH     = 32;
  localparam int BUS_ACC_WIDTH = 2;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_2B = 2'd1;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;
endpackage

interface bus_copy_initiator_if #(
  parameter int AW = 32
);
  import bus_copy_pkg::*;

  logic [AW-1:0]            addr;
  logic                     w_rb;
  logic [BUS_ACC_WIDTH-1:0] acc;
  logic [BUS_WIDTH-1:0]     wdata;
  logic                     req;
  logic [BUS_WIDTH-1:0]     rdata;
  logic                     resp;
  logic                     fault;

  modport master (
    output addr, w_rb, acc, wdata, req,
    input  rdata, resp, fault
  );

  modport slave (
    input  addr, w_rb, acc, wdata, req,
    output rdata, resp, fault
  );
endinterface

// File: rtl/bus_copy_initiator.sv
// Autonomous element-by-element block copy engine on the femto bus:
// read one element from src, write it to dst, repeat until len is spent.
module bus_copy_initiator
  import bus_copy_pkg::*;
#(
  parameter int AW      = 32,
  parameter int LW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [AW-1:0]            src,
  input  logic [AW-1:0]            dst,
  input  logic [LW-1:0]            len,
  input  logic [BUS_ACC_WIDTH-1:0] size,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               err_code,
  bus_copy_initiator_if.master     bus
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_FIN
  } state_t;

  state_t                   r_state, w_state_n;
  logic [AW-1:0]            r_src, r_dst;
  logic [LW-1:0]            r_rem;
  logic [BUS_ACC_WIDTH-1:0] r_size;
  logic [BUS_WIDTH-1:0]     r_data;
  logic [CW-1:0]            r_cnt;
  logic [1:0]               r_code, w_code_n;

  logic [2:0] w_in_b, w_b;
  logic [1:0] w_in_m;
  logic       w_bad, w_to;

  function automatic logic [2:0] elem_bytes(
    input logic [BUS_ACC_WIDTH-1:0] sz
  );
    logic [2:0] b;
    unique case (sz)
      BUS_ACC_1B: b = 3'd1;
      BUS_ACC_2B: b = 3'd2;
      BUS_ACC_4B: b = 3'd4;
      default:    b = 3'd0;
    endcase
    return b;
  endfunction

  // Low-bit mask of the element size: 1B->00, 2B->01, 4B->11.
  assign w_in_b = elem_bytes(size);
  assign w_in_m = w_in_b[1:0] - 2'd1;
  assign w_bad  = (w_in_b == 3'd0) ||
                  (|((len[1:0] | src[1:0] | dst[1:0]) & w_in_m));
  assign w_b    = elem_bytes(r_size);
  assign w_to   = (r_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_state_n = r_state;
    w_code_n  = r_code;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_code_n = 2'd0;
          if (w_bad) begin
            w_state_n = S_FIN;
            w_code_n  = 2'd3;
          end else if (len == '0) begin
            w_state_n = S_FIN;
          end else begin
            w_state_n = S_RD_REQ;
          end
        end
      end
      S_RD_REQ, S_WR_REQ: begin
        if (bus.fault) begin
          w_state_n = S_FIN;
          w_code_n  = 2'd1;
        end else if (r_state == S_RD_REQ) begin
          w_state_n = S_RD_WAIT;
        end else begin
          w_state_n = S_WR_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (bus.resp) begin
          w_state_n = S_WR_REQ;
        end else if (w_to) begin
          w_state_n = S_FIN;
          w_code_n  = 2'd2;
        end
      end
      S_WR_WAIT: begin
        if (bus.resp) begin
          if (r_rem == LW'(w_b)) w_state_n = S_FIN;
          else                   w_state_n = S_RD_REQ;
        end else if (w_to) begin
          w_state_n = S_FIN;
          w_code_n  = 2'd2;
        end
      end
      S_FIN:   w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_size  <= BUS_ACC_1B;
      r_data  <= '0;
      r_cnt   <= '0;
      r_code  <= 2'd0;
    end else begin
      r_state <= w_state_n;
      r_code  <= w_code_n;
      if (r_state == S_IDLE && start) begin
        r_src  <= src;
        r_dst  <= dst;
        r_rem  <= len;
        r_size <= size;
      end
      if (r_state == S_RD_WAIT && bus.resp) begin
        r_data <= bus.rdata;
      end
      if (r_state == S_WR_WAIT && bus.resp) begin
        r_src <= r_src + AW'(w_b);
        r_dst <= r_dst + AW'(w_b);
        r_rem <= r_rem - LW'(w_b);
      end
      // Wait counter restarts whenever the state changes.
      if (w_state_n != r_state) begin
        r_cnt <= '0;
      end else if (r_state == S_RD_WAIT || r_state == S_WR_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign busy     = (r_state != S_IDLE) && (r_state != S_FIN);
  assign done     = (r_state == S_FIN) && (r_code == 2'd0);
  assign err      = (r_state == S_FIN) && (r_code != 2'd0);
  assign err_code = r_code;

  assign bus.req   = (r_state == S_RD_REQ) || (r_state == S_WR_REQ);
  assign bus.w_rb  = (r_state == S_WR_REQ) || (r_state == S_WR_WAIT);
  assign bus.addr  = bus.w_rb ? r_dst : r_src;
  assign bus.acc   = r_size;
  assign bus.wdata = r_data;

endmodule

// File: tb/tb_bus_copy_initiator.sv
// Randomized bench for bus_copy_initiator: a transfer-level model predicts
// every bus request and the completion cycle, checked cycle by cycle.
module tb_bus_copy_initiator;
  import bus_copy_pkg::*;

  localparam int AW = 32;
  localparam int LW = 16;
  localparam int TO = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src, dst;
  logic [15:0] len;
  logic [1:0]  size;
  logic        busy, done, err;
  logic [1:0]  err_code;

  bus_copy_initiator_if #(.AW(AW)) bus ();

  bus_copy_initiator #(
    .AW(AW), .LW(LW), .TIMEOUT(TO)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .src(src), .dst(dst), .len(len), .size(size),
    .busy(busy), .done(done), .err(err),
    .err_code(err_code), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    int          t;
    int          dly;
    bit          flt;
    bit          nr;
  } op_t;

  op_t         ops[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] seed;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".req"}, bus.req, 1'b0);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".done"}, done, 1'b0);
    chk({tag, ".err"}, err, 1'b0);
    chk({tag, ".code"}, err_code, 2'd0);
    chk({tag, ".addr"}, bus.addr, 32'h0);
    chk({tag, ".w_rb"}, bus.w_rb, 1'b0);
    chk({tag, ".wdata"}, bus.wdata, 32'h0);
    chk({tag, ".acc"}, bus.acc, BUS_ACC_1B);
  endtask

  function automatic logic [31:0] memv(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  // Model: a copy is 2*len/b requests alternating read/write; each normal
  // request costs 2+delay cycles, a fault 1, a silent responder 1+TO.
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] l, input logic [1:0] sz,
                          input int flt_k, input int to_k,
                          input int dfix, input bit noise);
    op_t         o;
    int          b, n, t, fin, idx;
    logic [1:0]  code;
    bit          inwait, rsp_now;
    logic [31:0] rdv;
    ops.delete();
    seed = $urandom;
    case (sz)
      2'd0:    b = 1;
      2'd1:    b = 2;
      2'd2:    b = 4;
      default: b = 0;
    endcase
    code = 2'd0;
    t = 1;
    if (b == 0) code = 2'd3;
    else if ((int'(l) % b) != 0 || (s % b) != 0 || (d % b) != 0)
      code = 2'd3;
    else begin
      n = int'(l) / b;
      for (int k = 0; k < 2 * n && code == 2'd0; k++) begin
        o.wr  = (k % 2) == 1;
        o.a   = (o.wr ? d : s) + 32'((k / 2) * b);
        o.d   = memv(s + 32'((k / 2) * b));
        o.t   = t;
        o.flt = (k == flt_k);
        o.nr  = (k == to_k) && !o.flt;
        o.dly = (o.nr) ? TO - 1 :
                (dfix >= 0) ? dfix : int'($urandom_range(TO - 1, 0));
        if (o.flt) begin
          code = 2'd1;
          t += 1;
        end else if (o.nr) begin
          code = 2'd2;
          t += 1 + TO;
        end else begin
          t += 2 + o.dly;
        end
        ops.push_back(o);
      end
    end
    fin = t;
    bus.resp = 1'b0;
    bus.fault = 1'b0;
    start = 1'b1;
    src = s;
    dst = d;
    len = l;
    size = sz;
    for (int c = 1; c <= fin + 2; c++) begin
      @(posedge clk);
      #1;
      idx = -1;
      inwait = 1'b0;
      rsp_now = 1'b0;
      rdv = $urandom;
      foreach (ops[i]) begin
        if (ops[i].t == c) idx = i;
        if (!ops[i].flt && c > ops[i].t &&
            c <= ops[i].t + 1 + ops[i].dly) begin
          inwait = 1'b1;
          if (!ops[i].nr && c == ops[i].t + 1 + ops[i].dly) begin
            rsp_now = 1'b1;
            if (!ops[i].wr) rdv = ops[i].d;
          end
        end
      end
      chk("req", bus.req, idx >= 0);
      chk("busy", busy, c < fin);
      chk("done", done, c == fin && code == 2'd0);
      chk("err", err, c == fin && code != 2'd0);
      chk("err_code", err_code, (c >= fin) ? code : 2'd0);
      if (idx >= 0 && bus.req) begin
        chk("addr", bus.addr, ops[idx].a);
        chk("w_rb", bus.w_rb, ops[idx].wr);
        chk("acc", bus.acc, sz);
        if (ops[idx].wr) chk("wdata", bus.wdata, ops[idx].d);
      end
      bus.fault = (idx >= 0) ? ops[idx].flt :
                  (noise && $urandom_range(3, 0) == 0);
      bus.resp  = inwait ? rsp_now :
                  (noise && $urandom_range(1, 0) == 1);
      bus.rdata = rdv;
      if (noise && c <= fin && $urandom_range(1, 0) == 1) begin
        start = 1'b1;
        src = $urandom;
        dst = $urandom;
        len = 16'($urandom);
        size = 2'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    src = '0;
    dst = '0;
    len = '0;
    size = '0;
    bus.rdata = '0;
    bus.resp = 1'b0;
    bus.fault = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_idle("post_reset");

    run_xfer(32'h100, 32'h200, 16'd8, BUS_ACC_4B, -1, -1, 0, 1'b0);
    run_xfer(32'h100, 32'h200, 16'd6, BUS_ACC_4B, -1, -1, 0, 1'b0);
    run_xfer(32'h101, 32'h200, 16'd4, BUS_ACC_2B, -1, -1, 0, 1'b0);
    run_xfer(32'h100, 32'h202, 16'd4, BUS_ACC_4B, -1, -1, 0, 1'b0);
    run_xfer(32'h100, 32'h200, 16'd4, 2'd3, -1, -1, 0, 1'b0);
    run_xfer(32'h100, 32'h200, 16'd0, BUS_ACC_2B, -1, -1, 0, 1'b0);
    run_xfer(32'h300, 32'h400, 16'd4, BUS_ACC_1B, 3, -1, 0, 1'b0);
    run_xfer(32'h300, 32'h400, 16'd4, BUS_ACC_1B, -1, 0, 0, 1'b0);
    run_xfer(32'h300, 32'h400, 16'd4, BUS_ACC_2B, -1, 3, 0, 1'b0);
    run_xfer(32'h300, 32'h400, 16'd4, BUS_ACC_2B, -1, -1, TO - 1, 1'b0);

    // Reset while waiting for a write response, then a stray late resp.
    start = 1'b1;
    src = 32'h100;
    dst = 32'h200;
    len = 16'd8;
    size = BUS_ACC_4B;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("mr.rd_req", bus.req, 1'b1);
    @(posedge clk);
    #1;
    bus.resp = 1'b1;
    bus.rdata = 32'hA5A5_0001;
    @(posedge clk);
    #1;
    bus.resp = 1'b0;
    chk("mr.wr_req", bus.req, 1'b1);
    chk("mr.wdata", bus.wdata, 32'hA5A5_0001);
    @(posedge clk);
    #1;
    chk("mr.wr_wait", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_idle("mr.after_rst");
    bus.resp = 1'b1;
    @(posedge clk);
    #1;
    bus.resp = 1'b0;
    chk_idle("mr.late_resp");
    @(posedge clk);
    #1;
    chk_idle("mr.idle");

    run_xfer(32'h500, 32'h600, 16'd4, BUS_ACC_2B, -1, -1, 0, 1'b0);
    run_xfer(32'hFFFF_FFFE, 32'h40, 16'd4, BUS_ACC_2B, -1, -1, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  rsz;
      logic [31:0] rs, rd;
      logic [15:0] rl;
      int          bb, fk, tk;
      rsz = ($urandom_range(9, 0) == 0) ? 2'd3 : 2'($urandom_range(2, 0));
      bb = (rsz == 2'd3) ? 4 : (1 << rsz);
      rs = $urandom;
      rd = $urandom;
      if ($urandom_range(7, 0) != 0) begin
        rs[1:0] = 2'b00;
        rd[1:0] = 2'b00;
      end
      if ($urandom_range(5, 0) == 0) rs[31:4] = '1;
      rl = 16'($urandom_range(6, 0) * bb);
      if ($urandom_range(7, 0) == 0) rl = rl + 16'd1;
      fk = ($urandom_range(3, 0) == 0) ? int'($urandom_range(11, 0)) : -1;
      tk = ($urandom_range(3, 0) == 0) ? int'($urandom_range(11, 0)) : -1;
      run_xfer(rs, rd, rl, rsz, fk, tk, -1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
